// File: rtl/scope_pkg.sv
// Shared constants, FSM state encoding and pixel colours for the scope trace generator.
package scope_pkg;

  localparam int H_VISIBLE  = 640;
  localparam int V_VISIBLE  = 480;
  localparam int H_TOTAL    = 800;
  localparam int CENTRE_ROW = 240;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [2:0] b;
  } rgb_t;

  localparam rgb_t COL_BLACK = rgb_t'(9'b000_000_000);
  localparam rgb_t COL_TRACE = rgb_t'(9'b000_111_000);
  localparam rgb_t COL_TRIG  = rgb_t'(9'b100_000_000);
  localparam rgb_t COL_GRID  = rgb_t'(9'b000_000_010);

endpackage

// File: rtl/trace_ram.sv
// Two-bank sample store: one write port, one registered read port, addressed by {bank, index}.
module trace_ram #(
  parameter int SAMPLES = 640,
  parameter int IW      = $clog2(SAMPLES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we_i,
  input  logic          wr_bank_i,
  input  logic [IW-1:0] wr_idx_i,
  input  logic [7:0]    wr_data_i,
  input  logic          rd_bank_i,
  input  logic [IW-1:0] rd_idx_i,
  output logic [7:0]    rd_data_o
);

  logic [7:0] mem_q [2][SAMPLES];
  logic [7:0] rd_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[wr_bank_i][wr_idx_i] <= wr_data_i;
  end

  // Only the read register is reset; stale RAM is hidden by trace_valid upstream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_q <= '0;
    else       rd_q <= mem_q[rd_bank_i][rd_idx_i];
  end

  assign rd_data_o = rd_q;

endmodule

// File: rtl/scope_trace.sv
// Captures a triggered screen-width of ADC samples during vertical blank and renders
// the double-buffered trace, trigger line and graticule into the VGA pixel inputs.
module scope_trace
  import scope_pkg::*;
#(
  parameter int SAMPLES  = 640,
  parameter int Y_OFFSET = 112,
  parameter int GRID_X   = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] hcounter,
  input  logic [9:0]  vcounter,
  input  logic        lower_blank,
  input  logic [7:0]  adc_data,
  input  logic        adc_valid,
  input  logic [7:0]  trig_level,
  input  logic        auto_trig,
  output logic [2:0]  px_red,
  output logic [2:0]  px_grn,
  output logic [2:0]  px_blu,
  output logic        capturing,
  output logic        frame_done
);

  localparam int            IW       = $clog2(SAMPLES);
  localparam logic [IW-1:0] LAST_IDX = IW'(SAMPLES - 1);

  state_t        state_q, state_d;
  logic [IW-1:0] wr_idx_q, wr_idx_d;
  logic          disp_bank_q, disp_bank_d;
  logic          trace_valid_q, trace_valid_d;
  logic          below_q, below_d;
  logic          frame_done_q, frame_done_d;
  logic          lb_prev_q;
  logic          we;
  logic [IW-1:0] wr_addr;
  logic [IW-1:0] rd_idx;
  logic [7:0]    rd_sample;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      wr_idx_q      <= '0;
      disp_bank_q   <= 1'b0;
      trace_valid_q <= 1'b0;
      below_q       <= 1'b0;
      frame_done_q  <= 1'b0;
      lb_prev_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_idx_q      <= wr_idx_d;
      disp_bank_q   <= disp_bank_d;
      trace_valid_q <= trace_valid_d;
      below_q       <= below_d;
      frame_done_q  <= frame_done_d;
      lb_prev_q     <= lower_blank;
    end
  end

  always_comb begin
    state_d       = state_q;
    wr_idx_d      = wr_idx_q;
    disp_bank_d   = disp_bank_q;
    trace_valid_d = trace_valid_q;
    below_d       = below_q;
    frame_done_d  = 1'b0;
    we            = 1'b0;
    wr_addr       = wr_idx_q;
    case (state_q)
      ST_IDLE: begin
        wr_idx_d = '0;
        below_d  = 1'b0;
        if (lower_blank && !lb_prev_q) state_d = ST_ARM;
      end
      ST_ARM: begin
        // A low lower_blank here means it has fallen: abort before any write.
        if (!lower_blank) begin
          state_d = ST_IDLE;
        end else if (auto_trig) begin
          state_d  = ST_CAPTURE;
          wr_idx_d = '0;
        end else if (adc_valid) begin
          if (below_q && (adc_data >= trig_level)) begin
            we       = 1'b1;
            wr_addr  = '0;
            wr_idx_d = IW'(1);
            state_d  = ST_CAPTURE;
          end else begin
            below_d = (adc_data < trig_level);
          end
        end
      end
      ST_CAPTURE: begin
        if (!lower_blank) begin
          state_d = ST_IDLE;
        end else if (adc_valid) begin
          we = 1'b1;
          if (wr_idx_q == LAST_IDX) begin
            state_d       = ST_DONE;
            wr_idx_d      = '0;
            disp_bank_d   = ~disp_bank_q;
            trace_valid_d = 1'b1;
            frame_done_d  = 1'b1;
          end else begin
            wr_idx_d = wr_idx_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (!lower_blank) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Prefetch the next column so rd_sample lines up with the current hcounter.
  assign rd_idx = (hcounter < 11'(SAMPLES - 1)) ? (hcounter[IW-1:0] + 1'b1) : '0;

  trace_ram #(.SAMPLES(SAMPLES), .IW(IW)) u_ram (
    .clk       (clk),
    .reset     (reset),
    .we_i      (we),
    .wr_bank_i (~disp_bank_q),
    .wr_idx_i  (wr_addr),
    .wr_data_i (adc_data),
    .rd_bank_i (disp_bank_q),
    .rd_idx_i  (rd_idx),
    .rd_data_o (rd_sample)
  );

  logic [9:0] trace_row;
  logic [9:0] trig_row;
  logic       visible;
  logic       on_grid;
  rgb_t       pix;

  assign trace_row = 10'(Y_OFFSET) + {2'b00, ~rd_sample};
  assign trig_row  = 10'(Y_OFFSET) + {2'b00, ~trig_level};
  assign visible   = (hcounter < 11'(H_VISIBLE)) && (vcounter < 10'(V_VISIBLE));
  assign on_grid   = ((hcounter % 11'(GRID_X)) == 11'd0) || (vcounter == 10'(CENTRE_ROW));

  always_comb begin
    pix = COL_BLACK;
    if (visible) begin
      if (trace_valid_q && (vcounter == trace_row)) pix = COL_TRACE;
      else if (vcounter == trig_row)                pix = COL_TRIG;
      else if (on_grid)                             pix = COL_GRID;
    end
  end

  assign px_red     = pix.r;
  assign px_grn     = pix.g;
  assign px_blu     = pix.b;
  assign capturing  = (state_q == ST_ARM) || (state_q == ST_CAPTURE);
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_scope_trace.sv
// Self-checking bench for scope_trace: drives blanking intervals with ADC streams and
// probes rendered pixels against a sample-level reference model.
module tb_scope_trace;

  localparam int NS     = 640;
  localparam int MAXLEN = 2048;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] hcounter;
  logic [9:0]  vcounter;
  logic        lower_blank;
  logic [7:0]  adc_data;
  logic        adc_valid;
  logic [7:0]  trig_level;
  logic        auto_trig;
  logic [2:0]  px_red, px_grn, px_blu;
  logic        capturing;
  logic        frame_done;

  scope_trace dut (
    .clk         (clk),
    .reset       (reset),
    .hcounter    (hcounter),
    .vcounter    (vcounter),
    .lower_blank (lower_blank),
    .adc_data    (adc_data),
    .adc_valid   (adc_valid),
    .trig_level  (trig_level),
    .auto_trig   (auto_trig),
    .px_red      (px_red),
    .px_grn      (px_grn),
    .px_blu      (px_blu),
    .capturing   (capturing),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: contents of both banks, which one is shown, and whether any trace exists.
  int  exp_bank [2][NS];
  int  exp_disp  = 0;
  bit  exp_valid = 1'b0;

  bit         cyc_v [MAXLEN];
  logic [7:0] cyc_d [MAXLEN];

  int fd_count   = 0;
  int fd_run     = 0;
  int fd_max_run = 0;

  always @(negedge clk) begin
    if (frame_done === 1'b1) begin
      fd_count++;
      fd_run++;
      if (fd_run > fd_max_run) fd_max_run = fd_run;
    end else begin
      fd_run = 0;
    end
  end

  function automatic logic [8:0] ref_pix(input int h, input int v, input int s,
                                         input bit tv, input int lvl);
    if (h >= 640 || v >= 480)           return 9'b000_000_000;
    if (tv && v == 112 + 255 - s)       return 9'b000_111_000;
    if (v == 112 + 255 - lvl)           return 9'b100_000_000;
    if ((h % 64) == 0 || v == 240)      return 9'b000_000_010;
    return 9'b000_000_000;
  endfunction

  task automatic scan_point(input int h, input int v_extra, input string tag);
    int s;
    int vs [3];
    logic [8:0] got, exp;
    hcounter = (h == 0) ? 11'd639 : 11'(h - 1);
    vcounter = 10'd0;
    @(posedge clk); #1;
    hcounter = 11'(h);
    s = (exp_valid && h < NS) ? exp_bank[exp_disp][h] : 0;
    vs[0] = 112 + 255 - s;
    vs[1] = v_extra;
    vs[2] = 240;
    for (int k = 0; k < 3; k++) begin
      vcounter = 10'(vs[k]);
      #1;
      got = {px_red, px_grn, px_blu};
      exp = ref_pix(h, vs[k], s, exp_valid, int'(trig_level));
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s pixel h=%0d v=%0d got=%b expected=%b", tag, h, vs[k], got, exp);
      end
    end
  endtask

  task automatic check_display(input int n, input string tag);
    scan_point(0, 100, tag);
    scan_point(639, 300, tag);
    for (int i = 0; i < n; i++)
      scan_point($urandom_range(0, 639), $urandom_range(0, 479), tag);
  endtask

  task automatic run_blank(input int len, input bit auto_m, input logic [7:0] lvl,
                           input string tag);
    logic [7:0] exp_q [$];
    int  fd0;
    bit  trig, below, completed;
    auto_trig   = auto_m;
    trig_level  = lvl;
    vcounter    = 10'd490;
    lower_blank = 1'b1;
    fd0 = fd_count;
    for (int c = 0; c < len; c++) begin
      adc_valid = cyc_v[c];
      adc_data  = cyc_d[c];
      hcounter  = 11'(c % 800);
      @(posedge clk); #1;
      if (c == 0) begin
        checks++;
        if (capturing !== 1'b1) begin
          errors++;
          $display("FAIL %s capturing after blank start got=%b expected=1", tag, capturing);
        end
      end
    end
    // The falling edge carries a valid sample that must not be stored.
    lower_blank = 1'b0;
    adc_valid   = 1'b1;
    adc_data    = 8'hAA;
    @(posedge clk); #1;
    adc_valid = 1'b0;
    vcounter  = 10'd0;
    repeat (3) @(posedge clk);
    #1;

    trig  = 1'b0;
    below = 1'b0;
    for (int c = (auto_m ? 2 : 1); c < len && exp_q.size() < NS; c++) begin
      if (!cyc_v[c]) continue;
      if (!trig) begin
        if (auto_m || (below && cyc_d[c] >= lvl)) trig = 1'b1;
        else begin
          below = (cyc_d[c] < lvl);
          continue;
        end
      end
      exp_q.push_back(cyc_d[c]);
    end
    completed = (exp_q.size() == NS);
    if (completed) begin
      exp_disp  = 1 - exp_disp;
      exp_valid = 1'b1;
      for (int i = 0; i < NS; i++) exp_bank[exp_disp][i] = int'(exp_q[i]);
    end

    checks++;
    if ((fd_count - fd0) != (completed ? 1 : 0)) begin
      errors++;
      $display("FAIL %s frame_done pulses got=%0d expected=%0d", tag, fd_count - fd0,
               completed ? 1 : 0);
    end
    checks++;
    if (capturing !== 1'b0) begin
      errors++;
      $display("FAIL %s capturing after blank got=%b expected=0", tag, capturing);
    end
  endtask

  task automatic fill_ramp(input int len, input int base);
    for (int c = 0; c < len; c++) begin
      cyc_v[c] = 1'b1;
      cyc_d[c] = 8'(c + base);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (capturing !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset outputs capturing=%b frame_done=%b expected 0/0", capturing, frame_done);
    end
    scan_point(0, 100, "reset_grid");
    scan_point(64, 100, "reset_grid");
    scan_point(128, 367, "reset_trig");
    scan_point(700, 100, "reset_outside_h");
    scan_point(100, 500, "reset_outside_v");
    check_display(6, "reset_random");
  endtask

  task automatic test_ramp();
    fill_ramp(800, 254);
    run_blank(800, 1'b1, 8'd50, "ramp");
    scan_point(10, 357, "ramp_h10");
    check_display(12, "ramp_display");
  endtask

  task automatic test_trigger();
    for (int c = 0; c < 1200; c++) begin
      cyc_v[c] = (c >= 5) ? ($urandom_range(0, 9) != 0) : 1'b0;
      cyc_d[c] = 8'($urandom_range(0, 255));
    end
    cyc_v[1] = 1'b1; cyc_d[1] = 8'd100;
    cyc_v[2] = 1'b1; cyc_d[2] = 8'd127;
    cyc_v[3] = 1'b1; cyc_d[3] = 8'd128;
    cyc_v[4] = 1'b1; cyc_d[4] = 8'd200;
    run_blank(1200, 1'b0, 8'd128, "trigger");
    scan_point(0, 239, "trigger_idx0");
    scan_point(1, 167, "trigger_idx1");
    check_display(12, "trigger_display");
  endtask

  task automatic test_no_trigger();
    for (int c = 0; c < 900; c++) begin
      cyc_v[c] = 1'b1;
      cyc_d[c] = 8'd128;
    end
    run_blank(900, 1'b0, 8'd128, "no_trigger");
    check_display(8, "no_trigger_display");
  endtask

  task automatic test_slow_valid();
    for (int c = 0; c < 2000; c++) begin
      cyc_v[c] = ((c % 100) == 50);
      cyc_d[c] = 8'($urandom_range(0, 255));
    end
    run_blank(2000, 1'b1, 8'd0, "slow_valid");
    check_display(8, "slow_valid_display");
  endtask

  task automatic test_random();
    for (int it = 0; it < 3; it++) begin
      for (int c = 0; c < 1100; c++) begin
        cyc_v[c] = ($urandom_range(0, 3) != 0);
        cyc_d[c] = 8'($urandom_range(0, 255));
      end
      run_blank(1100, 1'b0, 8'($urandom_range(20, 235)), "random");
      check_display(8, "random_display");
    end
  endtask

  task automatic test_back_to_back();
    for (int it = 0; it < 2; it++) begin
      fill_ramp(800, int'($urandom_range(0, 255)));
      run_blank(800, 1'b1, 8'd10, "back_to_back");
      check_display(8, "back_to_back_display");
    end
  endtask

  task automatic test_reset_mid();
    fill_ramp(302, 254);
    auto_trig   = 1'b1;
    vcounter    = 10'd490;
    lower_blank = 1'b1;
    for (int c = 0; c < 302; c++) begin
      adc_valid = cyc_v[c];
      adc_data  = cyc_d[c];
      @(posedge clk); #1;
    end
    checks++;
    if (capturing !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid capturing before reset got=%b expected=1", capturing);
    end
    reset       = 1'b1;
    lower_blank = 1'b0;
    adc_valid   = 1'b0;
    #1;
    checks++;
    if (capturing !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid async outputs capturing=%b frame_done=%b expected 0/0",
               capturing, frame_done);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_valid = 1'b0;
    exp_disp  = 0;
    @(posedge clk); #1;
    check_display(8, "reset_mid_hidden");
    fill_ramp(800, int'($urandom_range(0, 255)));
    run_blank(800, 1'b1, 8'd200, "reset_mid_recapture");
    check_display(8, "reset_mid_recapture_display");
  endtask

  initial begin
    reset       = 1'b1;
    hcounter    = '0;
    vcounter    = '0;
    lower_blank = 1'b0;
    adc_data    = '0;
    adc_valid   = 1'b0;
    trig_level  = '0;
    auto_trig   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;

    test_reset();
    test_ramp();
    test_trigger();
    test_no_trigger();
    test_slow_valid();
    test_random();
    test_back_to_back();
    test_reset_mid();

    checks++;
    if (fd_max_run > 1) begin
      errors++;
      $display("FAIL frame_done width got=%0d cycles expected=1", fd_max_run);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
